// File: rtl/input_conditioner.sv
// input_conditioner
//   Conditions six raw push buttons into debounced levels, single-cycle press
//   pulses and a small command queue of button codes with auto-repeat.
//
// Ports
//   clk, rst_n            system clock, asynchronous active-low reset
//   left .. rotate_right  raw asynchronous buttons, codes 0..5 in that order
//   btn_level[5:0]        debounced stable level per button
//   btn_press[5:0]        one-cycle pulse on each debounced rising edge
//   cmd_valid             queue non-empty
//   cmd_data[2:0]         button code at the queue head
//   cmd_ready             consumer accepts the head entry
//   cmd_count[2:0]        queue occupancy, 0..4
//   cmd_dropped           sticky: an event was merged into a still-pending one
module input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       left,
  input  logic       right,
  input  logic       up,
  input  logic       down,
  input  logic       rotate_left,
  input  logic       rotate_right,
  output logic [5:0] btn_level,
  output logic [5:0] btn_press,
  output logic       cmd_valid,
  output logic [2:0] cmd_data,
  input  logic       cmd_ready,
  output logic [2:0] cmd_count,
  output logic       cmd_dropped
);

  localparam int NB     = 6;
  localparam int NR     = 4;
  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RP_W   = $clog2(RP_MAX + 1);

  localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_ONE   = DB_W'(1);
  localparam logic [RP_W-1:0] RP_FIRST = RP_W'(REPEAT_DELAY);
  localparam logic [RP_W-1:0] RP_NEXT  = RP_W'(REPEAT_PERIOD);
  localparam logic [RP_W-1:0] RP_ONE   = RP_W'(1);

  logic [NB-1:0]   raw, sync1, sync2, stable;
  logic [DB_W-1:0] db_cnt [NB];
  logic [RP_W-1:0] rep_cnt [NR];
  logic [NR-1:0]   rep_phase;
  logic [NR-1:0]   rep_hit;
  logic [NB-1:0]   event_vec, pending, grant;
  logic [2:0]      grant_code;
  logic            push, pop, push_ok;
  logic [2:0]      fifo_mem [4];
  logic [1:0]      wr_ptr, rd_ptr;

  assign raw = {rotate_right, rotate_left, down, up, right, left};

  // Two-flop synchronizer on every raw button.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Per-button debounce: the counter only runs while the synchronized input
  // disagrees with the stable value, so any bounce back restarts the wait.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable <= '0;
      for (int i = 0; i < NB; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (sync2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          stable[i] <= ~stable[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_ONE;
        end
      end
    end
  end

  // Level is the registered stable value; press marks the first cycle the
  // level reads 1, so both appear together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_level <= '0;
      btn_press <= '0;
    end else begin
      btn_level <= stable;
      btn_press <= stable & ~btn_level;
    end
  end

  // Auto-repeat for codes 0..3. The counter reads k on the k-th cycle after
  // the press cycle; after the first hit it restarts at 1 so the next hit
  // lands exactly REPEAT_PERIOD cycles later.
  always_comb begin
    rep_hit = '0;
    for (int i = 0; i < NR; i++) begin
      rep_hit[i] = btn_level[i] &&
                   (rep_cnt[i] == (rep_phase[i] ? RP_NEXT : RP_FIRST));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_phase <= '0;
      for (int i = 0; i < NR; i++) rep_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NR; i++) begin
        if (!btn_level[i]) begin
          rep_cnt[i]   <= '0;
          rep_phase[i] <= 1'b0;
        end else if (rep_hit[i]) begin
          rep_cnt[i]   <= RP_ONE;
          rep_phase[i] <= 1'b1;
        end else begin
          rep_cnt[i] <= rep_cnt[i] + RP_ONE;
        end
      end
    end
  end

  assign event_vec = btn_press | {2'b00, rep_hit};

  assign cmd_valid = (cmd_count != 3'd0);
  assign pop       = cmd_valid & cmd_ready;
  assign push_ok   = (cmd_count != 3'd4) | pop;
  assign cmd_data  = fifo_mem[rd_ptr];

  // Fixed-priority arbiter: lowest pending code wins. Scanning downward lets
  // the lowest set index overwrite any higher one.
  always_comb begin
    grant      = '0;
    grant_code = '0;
    push       = 1'b0;
    if (push_ok) begin
      for (int i = NB - 1; i >= 0; i--) begin
        if (pending[i]) begin
          grant      = '0;
          grant[i]   = 1'b1;
          grant_code = 3'(i);
          push       = 1'b1;
        end
      end
    end
  end

  // Pending bits: a new event overrides a same-cycle arbiter clear. An event
  // landing on an already-pending bit is merged and flagged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending     <= '0;
      cmd_dropped <= 1'b0;
    end else begin
      pending <= (pending & ~grant) | event_vec;
      if (|(event_vec & pending)) cmd_dropped <= 1'b1;
    end
  end

  // Four-entry FIFO. Storage is cleared on reset so the head reads code 0
  // while empty after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cmd_count <= '0;
      for (int i = 0; i < 4; i++) fifo_mem[i] <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= grant_code;
        wr_ptr           <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   cmd_count <= cmd_count + 3'd1;
        2'b01:   cmd_count <= cmd_count - 3'd1;
        default: cmd_count <= cmd_count;
      endcase
    end
  end

endmodule
